// File: rtl/mp64_phy_responder.sv
// Purpose : 64-bit burst memory responder behind a simple req/ready PHY port (single-port backing array).
// Latency : writes land in the handshake/beat cycle; read beat n appears RD_LAT+n cycles after acceptance.
// Backpress: phy_ready drops for the whole read burst; write beats stall on phy_req=0; reads cannot be stalled.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   phy_req               - request valid / write-beat valid during a write burst
//   phy_addr              - byte address; word index = phy_addr[AW+2:3]
//   phy_wen               - 1 = write burst, 0 = read burst (sampled at acceptance)
//   phy_wdata             - write beat data
//   phy_burst_len         - beats minus one (sampled at acceptance)
//   phy_rdata, phy_rvalid - registered read beat data / valid
//   phy_ready             - registered: a request (or write beat) can be taken
//   busy                  - high whenever the FSM is not idle
module mp64_phy_responder #(
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        phy_req,
    input  logic [63:0] phy_addr,
    input  logic        phy_wen,
    input  logic [63:0] phy_wdata,
    input  logic [7:0]  phy_burst_len,
    output logic [63:0] phy_rdata,
    output logic        phy_rvalid,
    output logic        phy_ready,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RLAT  = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t          state;
    logic [3:0]      lat_cnt;
    logic [8:0]      beat_cnt;
    logic [AW-1:0]   addr_q;
    logic [7:0]      len_q;

    logic [63:0]     mem [DEPTH];

    logic [AW-1:0]   req_idx;
    logic [AW-1:0]   cur_idx;
    logic            hs;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic            addr_unused;

    assign req_idx = phy_addr[AW+2:3];
    // Modulo-DEPTH beat address: the truncating cast makes bursts wrap past DEPTH-1 to word 0.
    assign cur_idx = addr_q + AW'(beat_cnt);
    assign hs      = (state == S_IDLE) && phy_req && phy_ready;
    assign busy    = (state != S_IDLE);

    // Byte-lane and upper address bits carry no meaning for a 64-bit word array.
    assign addr_unused = ^{phy_addr[63:AW+3], phy_addr[2:0]};

    // Write port: beat 0 lands on the handshake itself, later beats on every phy_req cycle in WRITE.
    // Reset forces IDLE with phy_ready low, so nothing is written while rst_n is low.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_idx;
        if (hs && phy_wen) begin
            mem_we    = 1'b1;
            mem_waddr = req_idx;
        end else if ((state == S_WRITE) && phy_req) begin
            mem_we    = 1'b1;
            mem_waddr = cur_idx;
        end
    end

    // Array contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= phy_wdata;
        end
    end

    // beat_cnt: in WRITE it is the index of the next beat to write; in RLAT/READ it is the
    // number of read beats already issued (so it is also the offset of the next one).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lat_cnt    <= 4'd0;
            beat_cnt   <= 9'd0;
            addr_q     <= '0;
            len_q      <= 8'd0;
            phy_rdata  <= 64'd0;
            phy_rvalid <= 1'b0;
            phy_ready  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    phy_ready <= 1'b1;
                    if (hs) begin
                        addr_q <= req_idx;
                        len_q  <= phy_burst_len;
                        if (phy_wen) begin
                            beat_cnt <= 9'd1;
                            if (phy_burst_len != 8'd0) begin
                                state <= S_WRITE;
                            end
                        end else begin
                            phy_ready <= 1'b0;
                            if (RD_LAT == 1) begin
                                // No latency cycles: beat 0 goes out on the very next cycle.
                                phy_rdata  <= mem[req_idx];
                                phy_rvalid <= 1'b1;
                                beat_cnt   <= 9'd1;
                                state      <= S_READ;
                            end else begin
                                lat_cnt  <= 4'(RD_LAT - 2);
                                beat_cnt <= 9'd0;
                                state    <= S_RLAT;
                            end
                        end
                    end
                end

                S_WRITE: begin
                    phy_ready <= 1'b1;
                    if (phy_req) begin
                        if (beat_cnt == {1'b0, len_q}) begin
                            state <= S_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                    end
                end

                S_RLAT: begin
                    phy_ready <= 1'b0;
                    if (lat_cnt == 4'd0) begin
                        phy_rdata  <= mem[cur_idx];
                        phy_rvalid <= 1'b1;
                        beat_cnt   <= beat_cnt + 9'd1;
                        state      <= S_READ;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end

                S_READ: begin
                    if (beat_cnt == ({1'b0, len_q} + 9'd1)) begin
                        // Last beat is on the bus this cycle; reopen the port next cycle.
                        phy_rvalid <= 1'b0;
                        phy_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        phy_rdata  <= mem[cur_idx];
                        phy_rvalid <= 1'b1;
                        phy_ready  <= 1'b0;
                        beat_cnt   <= beat_cnt + 9'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mp64_phy_responder.md
MP64_PHY_RESPONDER -- requirements
Module: mp64_phy_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning the number of 64-bit words in the backing array (power of two, 16..65536).
REQ-002 SHALL have parameter RD_LAT, default 2, meaning the cycles from read acceptance to the first read beat (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port phy_req, input, 1 bit: request valid, or write-beat valid during a write burst.
REQ-006 SHALL have port phy_addr, input, 64 bits: byte address; word index = phy_addr[log2(DEPTH)+2:3]; bits [2:0] and the upper bits are ignored.
REQ-007 SHALL have port phy_wen, input, 1 bit: 1 = write burst, 0 = read burst; sampled only at request acceptance.
REQ-008 SHALL have port phy_wdata, input, 64 bits: write beat data.
REQ-009 SHALL have port phy_burst_len, input, 8 bits: beats minus one (0 = 1 beat, 255 = 256 beats); sampled only at request acceptance.
REQ-010 SHALL have port phy_rdata, output, 64 bits: read beat data (registered).
REQ-011 SHALL have port phy_rvalid, output, 1 bit: read beat valid (registered); the requester cannot apply backpressure.
REQ-012 SHALL have port phy_ready, output, 1 bit: responder can accept a request or write beat (registered).
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, WRITE, RLAT and READ, with a 4-bit latency counter, a 9-bit beat counter and a word-address register.
REQ-015 SHALL accept a request in IDLE on a cycle where phy_req=1 and phy_ready=1 (the handshake); phy_req=1 with phy_ready=0 SHALL be ignored, with no state effect.
REQ-016 SHALL, on a write handshake, write phy_wdata to mem[word index] in that cycle, which counts as beat 0.
REQ-017 SHALL, after a write handshake with burst_len=0, remain in IDLE with phy_ready=1, so back-to-back single-beat writes run at 1 per cycle.
REQ-018 SHALL, after a write handshake with burst_len>0, enter WRITE with phy_ready=1.
REQ-019 SHALL, in WRITE, treat each cycle with phy_req=1 as one beat: write phy_wdata to mem[addr+n].
REQ-020 SHALL, in WRITE, treat a cycle with phy_req=0 as a stall: no write and no count.
REQ-021 SHALL ignore phy_addr, phy_wen and phy_burst_len while in WRITE.
REQ-022 SHALL return to IDLE after beat burst_len is written.
REQ-023 SHALL, on a read handshake, enter RLAT and drive phy_ready=0 from the next cycle until the burst completes.
REQ-024 SHALL, for a handshake in cycle 0, present read beat n in cycle RD_LAT+n with phy_rvalid=1 and phy_rdata=mem[addr+n], with no gaps, using RLAT then READ.
REQ-025 SHALL, for RD_LAT=1, skip RLAT and go directly to READ.
REQ-026 SHALL return to IDLE with phy_ready=1 in the cycle after the last read beat, i.e. cycle RD_LAT+burst_len+1.
REQ-027 SHALL compute all beat addresses as word index + n modulo DEPTH, so a burst crossing DEPTH-1 wraps to word 0.
REQ-028 SHALL hold phy_rdata at its last value while phy_rvalid=0.
REQ-029 SHALL NOT assert phy_rvalid outside READ.
REQ-030 SHALL return data written in an earlier cycle on a read of the same word (read-after-write); no write occurs during a read burst.
REQ-031 SHALL ignore phy_req in RLAT and READ.

Reset
REQ-032 SHALL, while rst_n=0, force state=IDLE, phy_ready=0, phy_rvalid=0, phy_rdata=0, busy=0, and clear all counters.
REQ-033 SHALL drive phy_ready=1 in the first cycle after rst_n rises.
REQ-034 SHALL, on reset asserted mid-burst, abort the burst immediately with no further writes or beats; array contents are not reset, and words written before the reset are retained.

Verification
REQ-035 SHALL be verified by: single write addr=0x40, wdata=0xDEADBEEF_CAFEF00D, len=0, then read addr=0x40, len=0 -> phy_rvalid for exactly 1 cycle, RD_LAT=2 cycles after acceptance, rdata=0xDEADBEEF_CAFEF00D.
REQ-036 SHALL be verified by: write burst addr=0x100, len=3, data 1,2,3,4, with phy_req dropped for 2 cycles between beats 1 and 2, then read len=3 -> 4 consecutive rvalid beats 1,2,3,4, and phy_ready low from the cycle after acceptance through the last beat.
REQ-037 SHALL be verified by: DEPTH=4096, write len=1 at word 4095 with data A,B, then read word 0 -> B, and read word 4095 -> A.
REQ-038 SHALL be verified by: read burst len=255 with phy_req held high throughout -> exactly 256 beats, no extra request accepted, and phy_ready=1 at cycle RD_LAT+256.
REQ-039 SHALL be verified by: rst_n pulsed low during beat 2 of a len=7 write at word 0 -> rvalid=0 and ready=0 during reset, ready=1 in the cycle after release, and a subsequent read len=7 returns beats 0-1 written and words 2-7 unchanged.
REQ-040 SHALL be verified by: back-to-back single-beat writes, 10 cycles with phy_req high -> 10 words written, with phy_ready high continuously.
